// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation, so the
// transmitter and receiver on the same link agree on the bit period.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned UartDataBits = 8;

  // Clocks per line bit; truncated, with no oversampling.
  function automatic int unsigned clk_per_bit(input int unsigned clk_hz,
                                              input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Counter width for a 0..n-1 counter; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-input handshake of the UART transmitter: the source drives data/valid, the
// transmitter answers with ready.
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes ahead of the serialiser; push is dropped when
// full and pop is dropped when empty. Asynchronous active-low reset empties it.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic [CntW-1:0]  w_count_d;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CntW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Full is judged before any same-edge pop, so a pop never frees room for a push.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_comb begin
    w_count_d = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered byte input, serialised as start, D0..D7 LSB
// first, stop. TX is registered and only changes at bit boundaries.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uart_tx_if.slave   s_if,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned ClkPerBit = clk_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CntW      = cnt_width(ClkPerBit);
  localparam logic [CntW-1:0] CntMax = CntW'(ClkPerBit - 1);
  localparam int unsigned FCntW     = $clog2(FIFO_DEPTH) + 1;

  if (ClkPerBit < 2) begin : g_cpb_chk
    $error("uart_tx: CLK_HZ/BIT_RATE must be at least 2");
  end

  uart_state_e                  r_state;
  uart_state_e                  w_state_d;
  logic [CntW-1:0]              r_clk_cnt;
  logic [CntW-1:0]              w_clk_cnt_d;
  logic [2:0]                   r_bit_idx;
  logic [2:0]                   w_bit_idx_d;
  logic [UartDataBits-1:0]      r_shift;
  logic [UartDataBits-1:0]      w_shift_d;
  logic                         r_tx;
  logic                         w_tx_d;

  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic [UartDataBits-1:0]      w_fifo_data;
  logic [FCntW-1:0]             w_fifo_count;
  logic                         w_push_fire;
  logic                         w_fifo_push;
  logic                         w_pop;
  logic                         w_cnt_done;
  logic                         w_bypass;

  assign s_if.ready  = !w_fifo_full;
  assign w_push_fire = s_if.valid && !w_fifo_full;
  assign w_cnt_done  = (r_clk_cnt == CntMax);

  // A byte arriving on the very edge the stop bit ends, with nothing queued, goes
  // straight into the shifter so back-to-back frames keep a zero idle gap.
  assign w_bypass    = (r_state == StStop) && w_cnt_done && w_fifo_empty && w_push_fire;
  assign w_fifo_push = w_push_fire && !w_bypass;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UartDataBits)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_fifo_push),
    .i_data  (s_if.data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_pop       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_d   = w_fifo_data;
          w_clk_cnt_d = '0;
          w_state_d   = StStart;
        end
      end
      StStart: begin
        if (w_cnt_done) begin
          w_clk_cnt_d = '0;
          w_bit_idx_d = '0;
          w_state_d   = StData;
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_cnt_done) begin
          w_clk_cnt_d = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_shift_d   = {1'b0, r_shift[UartDataBits-1:1]};
            w_bit_idx_d = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_cnt_done) begin
          w_clk_cnt_d = '0;
          if (!w_fifo_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_fifo_data;
            w_state_d = StStart;
          end else if (w_bypass) begin
            w_shift_d = s_if.data;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_clk_cnt_d = '0;
        w_state_d   = StIdle;
      end
    endcase

    // TX follows the next state, so it moves on the same edge as the state change.
    unique case (w_state_d)
      StIdle:  w_tx_d = 1'b1;
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      StStop:  w_tx_d = 1'b1;
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_tx      <= w_tx_d;
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = (r_state != StIdle) || (w_fifo_count != '0);

endmodule
